// File: rtl/mips_lsu_pkg.sv
// Shared types, byte-enable constants and op decode helpers for the MIPS load/store unit.
package mips_lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LBU = 3'd1,
        LH  = 3'd2,
        LHU = 3'd3,
        LW  = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    function automatic logic op_is_store(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [3:0] op_be(input lsu_op_t op);
        logic [3:0] be;
        case (op)
            LB, LBU, SB: be = BE_B;
            LH, LHU, SH: be = BE_H;
            default:     be = BE_W;
        endcase
        return be;
    endfunction

    // Halfwords need bit 0 clear, words need bits 1:0 clear; bytes never fault.
    function automatic logic op_misaligned(input lsu_op_t op, input logic [31:0] addr);
        logic bad;
        case (op)
            LH, LHU, SH: bad = addr[0];
            LW, SW:      bad = |addr[1:0];
            default:     bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mips_lsu_fmt.sv
// Load result formatter: sign/zero extension of the LSB-justified read lanes.
module mips_lsu_fmt
    import mips_lsu_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [31:0] raw,
    output logic [31:0] data
);

    always_comb begin
        data = raw;
        case (op)
            LB:      data = {{24{raw[7]}}, raw[7:0]};
            LBU:     data = {24'd0, raw[7:0]};
            LH:      data = {{16{raw[15]}}, raw[15:0]};
            LHU:     data = {16'd0, raw[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one outstanding op, IDLE->ISSUE->WAIT->RESP handshake to the bus controller.
// Define MIPS_LSU_ADDR_ERR_EN to fault misaligned halfword/word ops straight to RESP with resp_err.
module mips_lsu
    import mips_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    output logic        op_ready,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] address,
    output logic [31:0] write_data,
    output logic [3:0]  byteenable,
    output logic        read_select,
    output logic        write_select,
    input  logic [31:0] read_data,
    input  logic        busy
);

    lsu_state_t  state_reg;
    lsu_op_t     op_reg;
    lsu_op_t     op_in;
    logic [31:0] fmt_data;
    logic        err_now;

    assign op_in = lsu_op_t'(op_code);

    mips_lsu_fmt u_fmt (
        .op  (op_reg),
        .raw (read_data),
        .data(fmt_data)
    );

    assign op_ready = (state_reg == ST_IDLE) && !rst;

`ifdef MIPS_LSU_ADDR_ERR_EN
    logic err_reg;
    assign err_now  = op_misaligned(op_in, op_addr);
    assign resp_err = err_reg;
`else
    assign err_now  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            op_reg       <= LW;
            read_select  <= 1'b0;
            write_select <= 1'b0;
            resp_valid   <= 1'b0;
            resp_data    <= 32'd0;
            address      <= 32'd0;
            write_data   <= 32'd0;
            byteenable   <= BE_W;
`ifdef MIPS_LSU_ADDR_ERR_EN
            err_reg      <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (op_valid) begin
                        if (err_now) begin
                            // Faulting op never reaches the bus; bus-side registers keep their values.
                            resp_valid <= 1'b1;
                            resp_data  <= 32'd0;
`ifdef MIPS_LSU_ADDR_ERR_EN
                            err_reg    <= 1'b1;
`endif
                            state_reg  <= ST_RESP;
                        end else begin
                            op_reg       <= op_in;
                            address      <= op_addr;
                            write_data   <= op_wdata;
                            byteenable   <= op_be(op_in);
                            read_select  <= !op_is_store(op_in);
                            write_select <= op_is_store(op_in);
                            state_reg    <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    read_select  <= 1'b0;
                    write_select <= 1'b0;
                    state_reg    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (!busy) begin
                        resp_data  <= op_is_store(op_reg) ? 32'd0 : fmt_data;
                        resp_valid <= 1'b1;
                        state_reg  <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
`ifdef MIPS_LSU_ADDR_ERR_EN
                    err_reg    <= 1'b0;
`endif
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: driver queues expected bus and response events, monitor checks them.
module tb_mips_lsu;
    import mips_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op_code;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        op_ready;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  byteenable;
    logic        read_select;
    logic        write_select;
    logic [31:0] read_data;
    logic        busy;

    mips_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_code     (op_code),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .op_ready    (op_ready),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_err    (resp_err),
        .address     (address),
        .write_data  (write_data),
        .byteenable  (byteenable),
        .read_select (read_select),
        .write_select(write_select),
        .read_data   (read_data),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cycle;
    } resp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          cycle;
    } bus_t;

    resp_t resp_q[$];
    bus_t  bus_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: access width in bytes and the architectural load result.
    function automatic int size_of(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1 || op == 3'd5) return 1;
        if (op == 3'd2 || op == 3'd3 || op == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] op, input logic [31:0] rd);
        longint v;
        case (op)
            3'd0: begin v = rd % 256;   if (v >= 128)   v = v - 256;   end
            3'd1: v = rd % 256;
            3'd2: begin v = rd % 65536; if (v >= 32768) v = v - 65536; end
            3'd3: v = rd % 65536;
            3'd4: v = rd;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    task automatic wait_ready();
        int t = 0;
        @(negedge clk);
        while (!op_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("op_ready_wait", {31'd0, op_ready}, 32'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int b, input bit abort);
        int    n;
        int    sz;
        bit    err;
        bit    is_st;
        resp_t r;
        bus_t  q;
        wait_ready();
        op_valid  = 1'b1;
        op_code   = op;
        op_addr   = addr;
        op_wdata  = wdata;
        read_data = rd;
        n     = cyc;
        sz    = size_of(op);
        is_st = (op >= 3'd5);
`ifdef MIPS_LSU_ADDR_ERR_EN
        err = (addr % sz) != 0;
`else
        err = 1'b0;
`endif
        if (!err) begin
            q.wr    = is_st;
            q.addr  = addr;
            q.wdata = wdata;
            q.be    = 4'((1 << sz) - 1);
            q.cycle = n + 1;
            bus_q.push_back(q);
        end
        if (!abort) begin
            r.data  = (err || is_st) ? 32'd0 : load_value(op, rd);
            r.err   = err;
            r.cycle = err ? n + 1 : n + 3 + b;
            resp_q.push_back(r);
        end
        @(negedge clk);
        op_valid = 1'b0;
        busy     = (b > 0);
        if (abort) begin
            repeat (2) @(negedge clk);
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst  = 1'b0;
            busy = 1'b0;
            @(negedge clk);
            chk("op_ready_after_rst", {31'd0, op_ready}, 32'd1);
        end else begin
            repeat (b + 1) @(negedge clk);
            busy = 1'b0;
        end
    endtask

    // Monitor: bus-side issue events and responses are popped and compared as they appear.
    always @(negedge clk) begin
        if (read_select || write_select) begin
            if (bus_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL bus_unexpected: rd=%0b wr=%0b addr=0x%08h expected no select (cycle %0d)",
                         read_select, write_select, address, cyc);
            end else begin
                bus_t e;
                e = bus_q.pop_front();
                chk("bus_write_select", {31'd0, write_select}, {31'd0, e.wr});
                chk("bus_read_select", {31'd0, read_select}, {31'd0, !e.wr});
                chk("bus_address", address, e.addr);
                chk("bus_write_data", write_data, e.wdata);
                chk("bus_byteenable", {28'd0, byteenable}, {28'd0, e.be});
                chk("bus_cycle", cyc, e.cycle);
            end
        end
        if (resp_valid) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL resp_unexpected: resp_valid=1 data=0x%08h expected no response (cycle %0d)",
                         resp_data, cyc);
            end else begin
                resp_t e;
                e = resp_q.pop_front();
                chk("resp_data", resp_data, e.data);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
                chk("resp_cycle", cyc, e.cycle);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        op_valid  = 1'b0;
        op_code   = 3'd0;
        op_addr   = 32'd0;
        op_wdata  = 32'd0;
        read_data = 32'd0;
        busy      = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_op_ready", {31'd0, op_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_selects", {30'd0, read_select, write_select}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_byteenable", {28'd0, byteenable}, 32'h0000000F);
        rst = 1'b0;
        @(negedge clk);
        chk("op_ready_out_of_rst", {31'd0, op_ready}, 32'd1);

        do_op(3'd0, 32'h0000_1001, 32'h0,         32'h0000_0080, 0, 1'b0); // LB sign-extend
        do_op(3'd3, 32'h0000_2002, 32'h0,         32'h0000_BEEF, 3, 1'b0); // LHU with 3 busy cycles
        do_op(3'd7, 32'h0000_3000, 32'hDEAD_BEEF, 32'h1234_5678, 0, 1'b0); // SW
        do_op(3'd4, 32'h0000_4002, 32'h0,         32'hCAFE_F00D, 0, 1'b0); // misaligned LW
        do_op(3'd4, 32'h0000_5000, 32'h0,         32'h1111_2222, 5, 1'b1); // reset mid-WAIT
        do_op(3'd4, 32'h0000_6004, 32'h0,         32'h8765_4321, 1, 1'b0); // normal LW after abort
        do_op(3'd2, 32'h0000_7000, 32'h0,         32'hFFFF_8001, 0, 1'b0); // LH negative

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
            do_op(3'($urandom_range(0, 7)), a, $urandom, $urandom, $urandom_range(0, 3), 1'b0);
        end

        repeat (10) @(negedge clk);
        chk("resp_queue_drained", resp_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
MIPS_LSU -- requirements
Module: mips_lsu

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port: op_valid  in  1  CPU memory-op request.
REQ-004 SHALL have port: op_code  in  3  lsu_op_t: LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-005 SHALL have port: op_addr  in  32  byte address, unaligned allowed.
REQ-006 SHALL have port: op_wdata  in  32  store data, LSB-justified.
REQ-007 SHALL have port: op_ready  out  1  high only in IDLE and not in reset.
REQ-008 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_data  out  32  load result; resp_err  out  1  address error.
REQ-009 SHALL have ports to the bus controller: address  out  32; write_data  out  32; byteenable  out  4; read_select  out  1; write_select  out  1; read_data  in  32; busy  in  1.

Function
REQ-010 SHALL implement FSM IDLE, ISSUE, WAIT, RESP.
REQ-011 IDLE: on op_valid, latch op_code, op_addr and op_wdata, then go to ISSUE.
REQ-012 ISSUE: assert exactly one of read_select (loads) or write_select (stores) for exactly one cycle, then go to WAIT.
REQ-013 WAIT: selects low; each cycle sample busy; on busy==0 capture the formatted load data and go to RESP.
REQ-014 RESP: resp_valid=1 for exactly one cycle, then go to IDLE; op_valid is ignored while op_ready=0.
REQ-015 address SHALL equal the latched op_addr (unaligned, unmodified) from ISSUE through WAIT; the downstream controller shifts lanes by address[1:0].
REQ-016 write_data SHALL equal the latched op_wdata (unshifted).
REQ-017 byteenable SHALL be LSB-justified: B=4'b0001, H=4'b0011, W=4'b1111.
REQ-018 Load formatting SHALL be: LB sign-extend read_data[7:0]; LBU zero-extend [7:0]; LH sign-extend [15:0]; LHU zero-extend [15:0]; LW all 32 bits.
REQ-019 Stores SHALL return resp_data=0 and resp_err=0.
REQ-020 Zero-wait-state latency SHALL be: accept at cycle N, ISSUE at N+1, WAIT at N+2, resp_valid at N+3; each busy cycle adds one cycle.
REQ-021 Outside ISSUE and WAIT, address, write_data and byteenable SHALL hold their last values; selects SHALL be 0.

Reset
REQ-022 On rst: state=IDLE; read_select=0, write_select=0, resp_valid=0, resp_err=0, op_ready=0.
REQ-023 On rst: resp_data=0, address=0, write_data=0, byteenable=4'b1111.
REQ-024 rst asserted in any state, including mid-WAIT, SHALL abort the op with no response; the first cycle after rst deasserts is IDLE with op_ready=1.

Configuration
REQ-025 With macro MIPS_LSU_ADDR_ERR_EN defined: H ops with op_addr[0]!=0, and W ops with op_addr[1:0]!=0, SHALL skip ISSUE and WAIT (no select asserted) and go IDLE to RESP, giving resp_err=1 and resp_data=0, 1-cycle latency.
REQ-026 Without MIPS_LSU_ADDR_ERR_EN: no alignment check; resp_err is tied 0; misaligned ops are issued unchanged.

Structure
REQ-027 Package mips_lsu_pkg SHALL hold: lsu_op_t (3-bit enum, LB=0 ... SW=7); the state enum; byteenable constants BE_B, BE_H, BE_W.
REQ-028 Combinational sub-module mips_lsu_fmt SHALL perform the load sign/zero extension of REQ-018.

Verification
REQ-029 LB, addr 0x1001, read_data=0x00000080, busy never high -> resp_data=0xFFFFFF80 at N+3; byteenable=0001.
REQ-030 LHU, addr 0x2002, read_data=0x0000BEEF, busy high 3 cycles in WAIT -> resp_data=0x0000BEEF at N+6.
REQ-031 SW, addr 0x3000, wdata 0xDEADBEEF -> write_select high 1 cycle, byteenable=1111, write_data=0xDEADBEEF, resp_data=0.
REQ-032 ADDR_ERR_EN, LW at addr 0x4002 -> no select asserted, resp_valid at N+1, resp_err=1; without the macro, read_select is asserted at N+1.
REQ-033 rst pulsed in WAIT with busy=1 -> no resp_valid; op_ready=1 the cycle after rst deasserts; the next LW completes normally.
